// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter: CPU stores to BASE_ADDR queue bytes in a
// FIFO; status at BASE_ADDR+8 reports ready/idle/overflow/count.
module uart_tx_mmio #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        wr,
  input  logic [7:0]  strb,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned   PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW        = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [63:0]   STAT_ADDR = BASE_ADDR + 64'd8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic hit_data, hit_stat, push_req, push_ok, pop, ovf_clr, div_last;

  assign hit_data = en & (addr == BASE_ADDR);
  assign hit_stat = en & (addr == STAT_ADDR);
  assign push_req = hit_data & wr & strb[0];
  assign ovf_clr  = hit_stat & wr & strb[0] & wdata[2];
  assign div_last = (div_q == DIV_LAST);
  // A full FIFO still accepts when the serialiser frees a slot on the same edge.
  assign push_ok  = push_req & ((count_q < DEPTH_C) | pop);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = START;
        end
      end
      START: begin
        div_d = div_q + 16'd1;
        if (div_last) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        div_d = div_q + 16'd1;
        if (div_last) begin
          div_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        div_d = div_q + 16'd1;
        if (div_last) begin
          div_d   = '0;
          state_d = IDLE;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q & ~ovf_clr) | (push_req & ~push_ok);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (hit_stat && !wr) begin
      rdata[0]    = (count_q < DEPTH_C);
      rdata[1]    = (count_q == '0) && (state_q == IDLE);
      rdata[2]    = ovf_q;
      rdata[15:8] = 8'(count_q);
    end
  end

  assign tx   = tx_q;
  assign busy = (count_q != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a queue-based console model predicts pops, frames and
// status; a forked monitor decodes the tx line and checks frames against it.
module tb_uart_tx_mmio;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] STAT  = BASE + 64'd8;

  logic        clk, rstn, en, wr;
  logic [7:0]  strb;
  logic [63:0] addr, wdata, rdata;
  logic        tx, busy;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .en(en), .wr(wr), .strb(strb), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         st;
  } frame_t;

  // Reference model: byte queue, edge at which the current frame ends, sticky overflow.
  logic [7:0] mq[$];
  frame_t     exp_q[$];
  int         end_edge = 0;
  int         edge_n   = 0;
  int         rst_cnt  = 0;
  bit         m_ovf    = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [63:0] m_status();
    logic [63:0] s;
    s       = '0;
    s[0]    = (mq.size() < DEPTH);
    s[1]    = (mq.size() == 0) && (edge_n >= end_edge);
    s[2]    = m_ovf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  // Advance one clock; apply the edge to the model using the pre-edge bus values.
  task automatic tick();
    int     e;
    bit     pop, set_ovf;
    frame_t f;
    @(posedge clk);
    e = edge_n + 1;
    if (!rstn) begin
      mq.delete();
      exp_q.delete();
      end_edge = 0;
      m_ovf    = 1'b0;
      rst_cnt++;
    end else begin
      pop     = (mq.size() > 0) && (e >= end_edge);
      set_ovf = 1'b0;
      if (pop) begin
        f.b      = mq.pop_front();
        f.st     = e;
        exp_q.push_back(f);
        end_edge = e + 10 * D;
      end
      if (en && wr && strb[0] && addr == BASE) begin
        if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
        else set_ovf = 1'b1;
      end
      if (en && wr && strb[0] && addr == STAT && wdata[2]) m_ovf = 1'b0;
      if (set_ovf) m_ovf = 1'b1;
    end
    edge_n = e;
    #1;
  endtask

  task automatic drive(input logic e_, input logic w_, input logic [7:0] s_,
                       input logic [63:0] a_, input logic [63:0] d_);
    en = e_; wr = w_; strb = s_; addr = a_; wdata = d_;
  endtask

  task automatic bus_idle();
    drive(1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
  endtask

  task automatic wr_byte(input logic [63:0] a, input logic [7:0] b, input logic [7:0] s);
    drive(1'b1, 1'b1, s, a, {56'h0, b});
    tick();
  endtask

  task automatic rd_check(input string name, input logic [63:0] a);
    drive(1'b1, 1'b0, 8'h00, a, 64'h0);
    #1;
    chk(name, rdata, (a == STAT) ? m_status() : 64'h0);
    tick();
    bus_idle();
  endtask

  task automatic idle(input int n);
    bus_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string name);
    bit done;
    bus_idle();
    done = 1'b0;
    for (int i = 0; i < int'((DEPTH + 2) * 10 * D + 50); i++) begin
      if (exp_q.size() == 0 && mq.size() == 0 && edge_n >= end_edge) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 64'(done), 64'h1);
  endtask

  // Monitor: checks busy each cycle and decodes complete frames from tx.
  task automatic monitor();
    bit         in_frame = 1'b0;
    bit         bad      = 1'b0;
    int         st       = 0;
    int         o, k;
    int         seen_rst = rst_cnt;
    logic [9:0] bits     = '0;
    frame_t     e;
    forever begin
      @(negedge clk);
      if (rst_cnt != seen_rst) begin
        seen_rst = rst_cnt;
        in_frame = 1'b0;
      end
      chk("busy", 64'(busy), 64'((mq.size() != 0) || (edge_n < end_edge)));
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        st       = edge_n;
        bad      = 1'b0;
        bits     = '0;
      end
      if (in_frame) begin
        o = edge_n - st;
        k = o / D;
        if (o % D == 0) bits[k] = tx;
        else if (tx !== bits[k]) bad = 1'b1;
        if (o == int'(10 * D - 1)) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got bits %b at edge %0d, expected no frame", bits, st);
          end else begin
            e = exp_q.pop_front();
            chk("frame_bits", 64'(bits), 64'({1'b1, e.b, 1'b0}));
            chk("frame_start", 64'(st), 64'(e.st));
            chk("frame_stable", 64'(bad), 64'h0);
          end
        end
      end
    end
  endtask

  initial begin
    bus_idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    chk("reset_tx", 64'(tx), 64'h1);
    chk("reset_busy", 64'(busy), 64'h0);
    fork
      monitor();
    join_none
    rd_check("reset_status", STAT);

    // Single byte, then idle status.
    wr_byte(BASE, 8'h55, 8'h01);
    drain("t1_drain");
    rd_check("t1_status", STAT);

    // Nine consecutive writes, then ten writes into an empty FIFO mid-frame.
    for (int i = 0; i < 9; i++) wr_byte(BASE, 8'(i), 8'h01);
    rd_check("t2_status_full", STAT);
    bus_idle();
    for (int i = 0; i < 400 && mq.size() != 0; i++) tick();
    chk("t2_wait_empty", 64'(mq.size()), 64'h0);
    for (int i = 0; i < 10; i++) wr_byte(BASE, 8'(8'h40 + i), 8'h01);
    rd_check("t2_status_ovf", STAT);
    wr_byte(STAT, 8'h04, 8'h01);
    rd_check("t2_status_clr", STAT);
    drain("t2_drain");

    // Back-to-back frames; the monitor's start-edge check catches any gap.
    wr_byte(BASE, 8'hA5, 8'h01);
    wr_byte(BASE, 8'h3C, 8'h01);
    drain("t3_drain");

    // Accesses that must not push.
    wr_byte(BASE, 8'h77, 8'hFE);
    wr_byte(BASE + 64'd16, 8'h66, 8'hFF);
    rd_check("t4_load_data", BASE);
    rd_check("t4_status", STAT);
    idle(5);
    chk("t4_tx", 64'(tx), 64'h1);

    // Reset mid-DATA with bytes queued.
    wr_byte(BASE, 8'hFF, 8'h01);
    for (int i = 1; i <= 3; i++) wr_byte(BASE, 8'(i), 8'h01);
    idle(10);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t5_tx", 64'(tx), 64'h1);
    chk("t5_busy", 64'(busy), 64'h0);
    rd_check("t5_status", STAT);
    idle(100);

    // Status load with five bytes queued and a frame running.
    for (int i = 0; i < 6; i++) wr_byte(BASE, 8'(8'hC0 + i), 8'h01);
    rd_check("t6_status", STAT);
    rd_check("t6_status_again", STAT);
    drain("t6_drain");

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        wr_byte(BASE, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01);
        bus_idle();
      end else if (kind == 4) begin
        wr_byte(STAT, 8'($urandom), 8'($urandom));
        bus_idle();
      end else if (kind == 5) begin
        rd_check("rand_status", STAT);
      end else if (kind == 6) begin
        rd_check("rand_load", ($urandom_range(0, 1) == 0) ? BASE : BASE + 64'd16);
      end else if (kind == 7) begin
        wr_byte(BASE + 64'd16, 8'($urandom), 8'hFF);
        bus_idle();
      end else if (kind == 8 && $urandom_range(0, 15) == 0) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rand_reset_tx", 64'(tx), 64'h1);
      end else begin
        idle(int'($urandom_range(0, 30)));
      end
    end
    drain("final_drain");
    rd_check("final_status", STAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
